mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store port share one memory port.
// Round-robin on contention, bounded wait per access, and every output comes straight from a register.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Memory handshake: an access is offered while mem_valid=1 and completes on the
  // first rising edge that sees mem_ready=1; address, we and wdata stay frozen until then.
  // Requester handshake: a req seen high in IDLE starts a transaction that ends with
  // exactly one ack pulse; err qualifies that pulse only.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        owner_d;
  logic        last_d;
  logic        grant_d;

  // Data wins when it is alone, or when both ask and fetch was granted last.
  assign grant_d   = d_req & (~if_req | ~last_d);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      owner_d   <= 1'b0;
      last_d    <= 1'b1;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state     <= XFER;
            busy      <= 1'b1;
            mem_valid <= 1'b1;
            wait_cnt  <= 8'd0;
            owner_d   <= grant_d;
            last_d    <= grant_d;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_we    <= grant_d & d_we;
            mem_wdata <= grant_d ? d_wdata : 32'd0;
          end
        end
        XFER: begin
          if (mem_ready) begin
            state     <= ACK;
            mem_valid <= 1'b0;
            err       <= 1'b0;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            // Give up: the requester still gets its ack, flagged, with zeroed load data.
            state     <= ACK;
            mem_valid <= 1'b0;
            err       <= 1'b1;
            if (owner_d) begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= 32'd0;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          busy   <= 1'b0;
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          err    <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checked every cycle,
// plus literal expectations on the listed scenarios.
module tb_mem_arbiter;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        err;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        busy;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] edge_rd;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  // Memory read data changes mid-cycle so it is stable at every rising edge.
  initial forever begin
    @(negedge clk);
    mem_rdata = $urandom();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases are inferred from the expected observables: ack pending -> closing,
  // busy -> access outstanding, otherwise free to grant.
  logic        e_mem_valid = 0, e_mem_we = 0, e_if_ack = 0, e_d_ack = 0, e_err = 0, e_busy = 0;
  logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_d_rdata = 0;
  bit          m_owner_d = 0, m_last_d = 1;
  int          m_age = 0;

  task automatic model_finish(input bit timed_out);
    e_mem_valid = 0;
    e_err       = timed_out;
    if (m_owner_d) begin
      e_d_ack = 1;
      if (!e_mem_we) e_d_rdata = timed_out ? 32'd0 : mem_rdata;
    end else begin
      e_if_ack   = 1;
      e_if_rdata = timed_out ? 32'd0 : mem_rdata;
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_mem_valid = 0; e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
      e_if_ack = 0; e_d_ack = 0; e_err = 0; e_if_rdata = 0; e_d_rdata = 0;
      e_busy = 0; m_last_d = 1; m_age = 0;
    end else if (e_if_ack || e_d_ack) begin
      e_if_ack = 0; e_d_ack = 0; e_err = 0; e_busy = 0;
    end else if (e_busy) begin
      m_age = m_age + 1;
      if (mem_ready) model_finish(0);
      else if (m_age == TIMEOUT) model_finish(1);
    end else if (if_req || d_req) begin
      m_owner_d   = d_req && (!if_req || !m_last_d);
      m_last_d    = m_owner_d;
      m_age       = 0;
      e_busy      = 1;
      e_mem_valid = 1;
      e_mem_addr  = m_owner_d ? d_addr : if_addr;
      e_mem_we    = m_owner_d && d_we;
      e_mem_wdata = m_owner_d ? d_wdata : 32'd0;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    chk("mem_valid", mem_valid, e_mem_valid);
    chk("mem_we",    mem_we,    e_mem_we);
    chk("mem_addr",  mem_addr,  e_mem_addr);
    chk("mem_wdata", mem_wdata, e_mem_wdata);
    chk("if_ack",    if_ack,    e_if_ack);
    chk("d_ack",     d_ack,     e_d_ack);
    chk("err",       err,       e_err);
    chk("if_rdata",  if_rdata,  e_if_rdata);
    chk("d_rdata",   d_rdata,   e_d_rdata);
    chk("busy",      busy,      e_busy);
    if (if_ack && d_ack) chk("ack_overlap", 32'd1, 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    edge_rd = mem_rdata;
    #1;
  endtask

  task automatic do_reset();
    if_req = 0; d_req = 0; mem_ready = 0;
    rst = 0;
    tick();
    tick();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    rst = 1;
  endtask

  // Called in the IDLE cycle with requests already driven; returns in the ACK cycle.
  task automatic run_xact(input int ready_at, input bit hold, input logic [31:0] exp_addr,
                          input bit exp_we, input bit chg, input logic [31:0] chg_addr,
                          output int nv, output bit ai, output bit ad);
    nv = 0; ai = 0; ad = 0;
    tick();
    chk("xfer_mem_valid", mem_valid, 1);
    chk("xfer_mem_addr", mem_addr, exp_addr);
    chk("xfer_mem_we", mem_we, exp_we);
    if (!hold) begin if_req = 0; d_req = 0; end
    if (chg) if_addr = chg_addr;
    for (int i = 0; i < 40; i++) begin
      if (if_ack || d_ack) begin ai = if_ack; ad = d_ack; break; end
      if (mem_valid) nv++;
      mem_ready = (ready_at != 0) && (nv == ready_at);
      tick();
    end
    mem_ready = 0;
    if (!ai && !ad) chk("ack_wait_bound", 32'd0, 32'd1);
  endtask

  // ---------------- directed scenarios ----------------
  int nv;
  bit ai, ad;
  logic [31:0] prev_d;

  initial begin
    #1;
    do_reset();

    // Single fetch at minimum latency.
    if_addr = 32'h100; if_req = 1;
    run_xact(1, 0, 32'h100, 0, 0, 0, nv, ai, ad);
    chk("fetch_ack", ai, 1);
    chk("fetch_nodack", ad, 0);
    chk("fetch_rdata", if_rdata, edge_rd);
    chk("fetch_nv", nv, 1);
    tick();
    chk("fetch_ack_one_cycle", if_ack, 0);

    // Fetch address moves while the access waits.
    if_addr = 32'h100; if_req = 1;
    run_xact(3, 0, 32'h100, 0, 1, 32'h200, nv, ai, ad);
    chk("addr_hold_at_ack", mem_addr, 32'h100);
    chk("addr_hold_ack", ai, 1);
    tick();

    // Plain load so d_rdata holds something non-zero.
    d_addr = 32'h1000; d_we = 0; d_req = 1;
    run_xact(2, 0, 32'h1000, 0, 0, 0, nv, ai, ad);
    chk("load_ack", ad, 1);
    chk("load_rdata", d_rdata, edge_rd);
    prev_d = edge_rd;
    tick();

    // Store completing on the third memory cycle.
    d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_we = 1; d_req = 1;
    run_xact(3, 0, 32'h2000, 1, 0, 0, nv, ai, ad);
    chk("store_nv", nv, 3);
    chk("store_ack", ad, 1);
    chk("store_noifack", ai, 0);
    chk("store_err", err, 0);
    chk("store_wdata", mem_wdata, 32'hCAFEF00D);
    chk("store_d_rdata_held", d_rdata, prev_d);
    tick();
    d_we = 0;

    // Load that never sees mem_ready.
    d_addr = 32'h3000; d_req = 1;
    run_xact(0, 0, 32'h3000, 0, 0, 0, nv, ai, ad);
    chk("timeout_nv", nv, 16);
    chk("timeout_ack", ad, 1);
    chk("timeout_err", err, 1);
    chk("timeout_rdata", d_rdata, 0);
    tick();
    chk("timeout_err_clear", err, 0);

    // mem_ready arrives exactly in the last allowed cycle.
    d_addr = 32'h3004; d_req = 1;
    run_xact(16, 0, 32'h3004, 0, 0, 0, nv, ai, ad);
    chk("lastcycle_nv", nv, 16);
    chk("lastcycle_err", err, 0);
    chk("lastcycle_rdata", d_rdata, edge_rd);
    tick();

    // Both requesters held high after reset: fetch, data, fetch, data.
    do_reset();
    if_addr = 32'h300; d_addr = 32'h400; d_we = 0;
    if_req = 1; d_req = 1;
    for (int k = 0; k < 4; k++) begin
      run_xact(1, 1, (k % 2 == 0) ? 32'h300 : 32'h400, 0, 0, 0, nv, ai, ad);
      chk("rr_if_ack", ai, (k % 2 == 0) ? 1 : 0);
      chk("rr_d_ack", ad, (k % 2 == 0) ? 0 : 1);
      tick();
    end
    if_req = 0; d_req = 0;
    tick();

    // Reset dropped in the middle of an access.
    if_addr = 32'h500; d_addr = 32'h600;
    if_req = 1; d_req = 1; mem_ready = 0;
    tick();
    chk("pre_rst_valid", mem_valid, 1);
    tick();
    #2;
    rst = 0;
    #1;
    chk("async_mem_valid", mem_valid, 0);
    chk("async_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("no_ack_in_reset", if_ack | d_ack, 0);
    end
    rst = 1;
    run_xact(1, 0, 32'h500, 0, 0, 0, nv, ai, ad);
    chk("post_rst_fetch_first", ai, 1);
    chk("post_rst_no_dack", ad, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
